ada_add_arbiter: RTL and testbench
==================================

ADA_ADD_ARBITER -- requirements
Module: ada_add_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, operand/result width; all widths below use 32.
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous, active-high.
REQ-004 Port: req_valid  input  4  per-requester add request; bit i = requester i.
REQ-005 Port: req_a  input  128  packed operand A; requester i at bits [32*i+31:32*i].
REQ-006 Port: req_b  input  128  packed operand B; same packing as req_a.
REQ-007 Port: req_ready  output  4  one-hot acceptance strobe; at most one bit high per cycle.
REQ-008 Port: rsp_valid  output  4  one-hot result-valid, bit i addresses requester i.
REQ-009 Port: rsp_data  output  32  result for the requester flagged in rsp_valid.
REQ-010 Port: rsp_ready  input  4  per-requester result acceptance.
REQ-011 Port: add_a  output  32  operand A to the shared 32-bit adder.
REQ-012 Port: add_b  output  32  operand B to the shared 32-bit adder.
REQ-013 Port: add_c  input  32  sum returned by the shared adder (combinational A+B).
REQ-014 Port: busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-015 The block SHALL arbitrate four requesters onto one external adder, one operation in flight.
REQ-016 FSM states SHALL be IDLE, EXEC, RESP; reset state IDLE.
REQ-017 In IDLE with any req_valid set, the block SHALL grant requester g chosen round-robin: first set bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-018 req_ready[g] SHALL be asserted combinationally in that IDLE cycle only; a handshake is req_valid[g] & req_ready[g].
REQ-019 On handshake the block SHALL latch req_a/req_b slice g into operand registers, latch g, and go to EXEC.
REQ-020 In IDLE with no req_valid, the block SHALL stay IDLE and hold all registers.
REQ-021 add_a/add_b SHALL always equal the operand registers.
REQ-022 In EXEC (exactly one cycle) the block SHALL register add_c into the result register and go to RESP.
REQ-023 In RESP, rsp_valid[g] SHALL be 1, other bits 0, rsp_data = result register; both held stable until rsp_ready[g].
REQ-024 On rsp_valid[g] & rsp_ready[g], the block SHALL go to IDLE and set ptr = (g+1) mod 4.
REQ-025 rsp_ready bits other than g SHALL be ignored.
REQ-026 req_ready SHALL be 0 in EXEC and RESP; requests wait, no new acceptance until IDLE.
REQ-027 Latency: handshake at cycle T -> rsp_valid at T+2; minimum 3 cycles per operation.
REQ-028 Arithmetic SHALL be modulo 2^32; carry-out discarded (0xFFFFFFFF + 1 = 0x00000000).
REQ-029 A requester deasserting req_valid before grant SHALL simply not be granted; no state change.
REQ-030 rsp_valid SHALL be 0 in IDLE and EXEC.

Reset
REQ-031 While rst=1: state IDLE, ptr 0, operand, result and grant registers 0; req_ready, rsp_valid, busy, add_a, add_b, rsp_data all 0.
REQ-032 Reset asserted mid-operation (EXEC or RESP) SHALL discard the operation; no response issued after release.
REQ-033 First cycle after release SHALL behave as IDLE with ptr 0.

Verification
REQ-034 Single request: req_valid=0001, a0=5, b0=7 -> req_ready=0001 same cycle; two cycles later rsp_valid=0001, rsp_data=12; busy high for EXEC and RESP.
REQ-035 Overflow: a=0xFFFFFFFF, b=0x00000002 -> rsp_data=0x00000001.
REQ-036 Round-robin: req_valid=1111 held, rsp_ready=1111 -> grant order 0,1,2,3,0; each grant 3 cycles apart.
REQ-037 Backpressure: rsp_ready[g]=0 for 5 cycles in RESP -> rsp_valid/rsp_data stable 5 cycles, req_ready=0000 throughout, release on rsp_ready[g]=1.
REQ-038 Wrong ready: granted requester 2, rsp_ready=1011 -> stays RESP; rsp_ready=0100 -> IDLE, ptr=3.
REQ-039 Reset in EXEC: rst pulsed one cycle -> all outputs 0 immediately, no rsp_valid after release, next grant to lowest set req_valid bit from ptr 0.

Source files
------------

// File: rtl/ada_add_arbiter.sv
// Round-robin arbiter sharing one external adder among four requesters.
// One operation in flight: IDLE grants, EXEC captures the sum, RESP holds it until the owner acks.
module ada_add_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              req_valid,
  input  logic [4*DATA_WIDTH-1:0] req_a,
  input  logic [4*DATA_WIDTH-1:0] req_b,
  output logic [3:0]              req_ready,
  output logic [3:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  input  logic [3:0]              rsp_ready,
  output logic [DATA_WIDTH-1:0]   add_a,
  output logic [DATA_WIDTH-1:0]   add_b,
  input  logic [DATA_WIDTH-1:0]   add_c,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_r;
  logic [1:0]            ptr_r;
  logic [1:0]            grant_r;
  logic [DATA_WIDTH-1:0] op_a_r;
  logic [DATA_WIDTH-1:0] op_b_r;
  logic [DATA_WIDTH-1:0] result_r;

  logic [1:0]            pick_s;
  logic [1:0]            idx_s;
  logic                  handshake_s;

  // Round-robin pick: scanning from the far end lets the nearest set bit after ptr win.
  always_comb begin
    pick_s = ptr_r;
    idx_s  = ptr_r;
    for (int i = 3; i >= 0; i--) begin
      idx_s  = ptr_r + 2'(i);
      pick_s = req_valid[idx_s] ? idx_s : pick_s;
    end
  end

  // Acceptance strobe only in IDLE and never while reset is held.
  always_comb begin
    req_ready = 4'b0000;
    if (state_r == IDLE && !rst && (|req_valid)) begin
      req_ready = 4'b0001 << pick_s;
    end else begin
      req_ready = 4'b0000;
    end
  end

  assign handshake_s = |(req_valid & req_ready);

  // Response strobe and status derive purely from registered state.
  always_comb begin
    rsp_valid = 4'b0000;
    if (state_r == RESP) begin
      rsp_valid = 4'b0001 << grant_r;
    end else begin
      rsp_valid = 4'b0000;
    end
  end

  assign busy     = (state_r != IDLE);
  assign add_a    = op_a_r;
  assign add_b    = op_b_r;
  assign rsp_data = result_r;

  // Control FSM with operand, grant, pointer and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      ptr_r    <= 2'd0;
      grant_r  <= 2'd0;
      op_a_r   <= {DATA_WIDTH{1'b0}};
      op_b_r   <= {DATA_WIDTH{1'b0}};
      result_r <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (handshake_s) begin
            op_a_r  <= req_a[pick_s*DATA_WIDTH +: DATA_WIDTH];
            op_b_r  <= req_b[pick_s*DATA_WIDTH +: DATA_WIDTH];
            grant_r <= pick_s;
            state_r <= EXEC;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          result_r <= add_c;
          state_r  <= RESP;
        end
        RESP: begin
          // Only the owner's ready bit matters; others are ignored.
          if (rsp_ready[grant_r]) begin
            ptr_r   <= grant_r + 2'd1;
            state_r <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ada_add_arbiter.sv
// Directed self-checking bench for ada_add_arbiter; the external adder is modelled here.
module tb_ada_add_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_ready;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_data;
  logic [3:0]   rsp_ready;
  logic [31:0]  add_a;
  logic [31:0]  add_b;
  logic [31:0]  add_c;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_sum [4];
  logic [3:0]  exp_ready;
  logic [3:0]  exp_rv;

  always #5 clk = ~clk;

  assign add_c = add_a + add_b;

  ada_add_arbiter #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_c     (add_c),
    .busy      (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'b0000;
    req_a     = 128'd0;
    req_b     = 128'd0;
    rsp_ready = 4'b0000;
    tick;
    tick;

    // Outputs held at zero during reset even with requests pending
    req_valid = 4'b1111;
    req_a     = {4{32'hAAAA5555}};
    #1;
    chk("rst_req_ready", {28'd0, req_ready}, 32'h0);
    chk("rst_rsp_valid", {28'd0, rsp_valid}, 32'h0);
    chk("rst_busy",      {31'd0, busy},      32'h0);
    chk("rst_add_a",     add_a,              32'h0);
    chk("rst_add_b",     add_b,              32'h0);
    chk("rst_rsp_data",  rsp_data,           32'h0);
    req_valid = 4'b0000;
    req_a     = 128'd0;
    rst       = 1'b0;
    tick;

    // Single request on requester 0: 5 + 7
    req_a[31:0] = 32'd5;
    req_b[31:0] = 32'd7;
    req_valid   = 4'b0001;
    #1;
    chk("t1_ready",     {28'd0, req_ready}, 32'h1);
    chk("t1_idle_busy", {31'd0, busy},      32'h0);
    tick;
    req_valid = 4'b0000;
    #1;
    chk("t1_exec_busy",  {31'd0, busy},      32'h1);
    chk("t1_exec_rv",    {28'd0, rsp_valid}, 32'h0);
    chk("t1_exec_ready", {28'd0, req_ready}, 32'h0);
    chk("t1_add_a",      add_a,              32'd5);
    chk("t1_add_b",      add_b,              32'd7);
    tick;
    chk("t1_rsp_valid", {28'd0, rsp_valid}, 32'h1);
    chk("t1_rsp_data",  rsp_data,           32'd12);
    chk("t1_resp_busy", {31'd0, busy},      32'h1);
    rsp_ready = 4'b0001;
    tick;
    rsp_ready = 4'b0000;
    #1;
    chk("t1_done_busy", {31'd0, busy},      32'h0);
    chk("t1_done_rv",   {28'd0, rsp_valid}, 32'h0);

    // Overflow on requester 1 (pointer now 1)
    req_a[63:32] = 32'hFFFFFFFF;
    req_b[63:32] = 32'h00000002;
    req_valid    = 4'b0010;
    #1;
    chk("ov_ready", {28'd0, req_ready}, 32'h2);
    tick;
    req_valid = 4'b0000;
    tick;
    chk("ov_rsp_valid", {28'd0, rsp_valid}, 32'h2);
    chk("ov_rsp_data",  rsp_data,           32'h00000001);
    rsp_ready = 4'b0010;
    tick;
    rsp_ready = 4'b0000;

    // Backpressure on requester 2 with the wrong ready bits asserted
    req_a[95:64]  = 32'h12340000;
    req_b[95:64]  = 32'h00005678;
    req_a[127:96] = 32'd50;
    req_b[127:96] = 32'd9;
    req_valid     = 4'b0100;
    #1;
    chk("bp_grant", {28'd0, req_ready}, 32'h4);
    tick;
    req_valid = 4'b1111;
    tick;
    rsp_ready = 4'b1011;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_rsp_valid", {28'd0, rsp_valid}, 32'h4);
      chk("bp_rsp_data",  rsp_data,           32'h12345678);
      chk("bp_req_ready", {28'd0, req_ready}, 32'h0);
      chk("bp_busy",      {31'd0, busy},      32'h1);
      tick;
    end
    rsp_ready = 4'b0100;
    tick;
    rsp_ready = 4'b0000;
    #1;
    chk("wr_ptr3_grant", {28'd0, req_ready}, 32'h8);
    chk("wr_idle_busy",  {31'd0, busy},      32'h0);

    // Reset during EXEC discards the operation
    tick;
    chk("re_exec_busy", {31'd0, busy}, 32'h1);
    chk("re_exec_a",    add_a,         32'd50);
    rst = 1'b1;
    #1;
    chk("re_busy",      {31'd0, busy},      32'h0);
    chk("re_add_a",     add_a,              32'h0);
    chk("re_add_b",     add_b,              32'h0);
    chk("re_req_ready", {28'd0, req_ready}, 32'h0);
    chk("re_rsp_valid", {28'd0, rsp_valid}, 32'h0);
    tick;
    rst       = 1'b0;
    req_valid = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("re_post_rv",   {28'd0, rsp_valid}, 32'h0);
      chk("re_post_busy", {31'd0, busy},      32'h0);
      tick;
    end
    req_valid = 4'b0110;
    #1;
    chk("re_grant_ptr0", {28'd0, req_ready}, 32'h2);
    tick;
    req_valid = 4'b0000;
    tick;
    chk("re_rsp_data", rsp_data, 32'h00000001);
    rsp_ready = 4'b1111;
    tick;
    rsp_ready = 4'b0000;

    // Round-robin with all requesters active and always-ready consumers
    rst = 1'b1;
    tick;
    rst = 1'b0;
    req_a   = {32'd400, 32'd300, 32'd200, 32'd100};
    req_b   = {32'd4,   32'd3,   32'd2,   32'd1};
    exp_sum = '{32'd101, 32'd202, 32'd303, 32'd404};
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    for (int k = 0; k < 15; k++) begin
      #1;
      exp_ready = (k % 3 == 0) ? (4'b0001 << ((k / 3) % 4)) : 4'b0000;
      exp_rv    = (k % 3 == 2) ? (4'b0001 << ((k / 3) % 4)) : 4'b0000;
      chk("rr_req_ready", {28'd0, req_ready}, {28'd0, exp_ready});
      chk("rr_rsp_valid", {28'd0, rsp_valid}, {28'd0, exp_rv});
      if (k % 3 == 2) begin
        chk("rr_rsp_data", rsp_data, exp_sum[(k / 3) % 4]);
      end
      tick;
    end
    req_valid = 4'b0000;
    rsp_ready = 4'b0000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
